// File: rtl/sub_result_fifo.sv
// rtl/sub_result_fifo.sv - result FIFO behind the subtractor with borrow split and saturating borrow counter
//
// Captures the (DATA_WIDTH+1)-bit subtractor result X into a DEPTH-entry FIFO.
// The head entry is presented as a wrapped difference plus a borrow flag.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   clr          synchronous flush of FIFO contents and borrow counter
//   in_valid     upstream result valid
//   in_ready     FIFO can accept (not full)
//   in_x         subtractor result X
//   out_valid    head entry available (not empty)
//   out_ready    consumer takes head entry
//   out_diff     head X[DATA_WIDTH-1:0], zero when empty
//   out_borrow   head X[DATA_WIDTH], zero when empty
//   count        occupancy 0..DEPTH
//   full, empty  occupancy flags
//   borrow_cnt   saturating number of accepted entries with borrow set
module sub_result_fifo #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH:0]      in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_diff,
    output logic                     out_borrow,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_WIDTH-1:0]     borrow_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                push;
    logic                pop;
    logic [DATA_WIDTH:0] head;

    // Flags come from registered occupancy only, so in_ready never
    // depends combinationally on out_ready.
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Head data is masked while empty so stale storage never leaks out.
    assign head       = mem[rd_ptr];
    assign out_diff   = empty ? '0 : head[DATA_WIDTH-1:0];
    assign out_borrow = empty ? 1'b0 : head[DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            borrow_cnt <= '0;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            borrow_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && in_x[DATA_WIDTH] && (borrow_cnt != '1)) begin
                borrow_cnt <= borrow_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= in_x;
        end
    end

endmodule

// File: tb/tb_sub_result_fifo.sv
// tb/tb_sub_result_fifo.sv - self-checking bench for sub_result_fifo
module tb_sub_result_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [4:0] in_x = '0;

    logic       in_ready, out_valid, out_borrow, full, empty;
    logic [3:0] out_diff;
    logic [2:0] count;
    logic [7:0] borrow_cnt;

    logic       in_ready_s, out_valid_s, out_borrow_s, full_s, empty_s;
    logic [3:0] out_diff_s;
    logic [2:0] count_s;
    logic [1:0] borrow_cnt_s;

    int n_pass = 0;
    int n_total = 0;

    logic [4:0] sb[$];
    logic [4:0] got[$];
    int m_bc = 0;
    int m_bc2 = 0;

    typedef struct {
        bit         iv;
        bit         ordy;
        logic [4:0] x;
        int         cnt;
        bit         ov;
        int         diff;
        bit         brw;
        bit         fl;
        int         bc;
    } vec_t;

    vec_t vecs[13];

    sub_result_fifo #(.DATA_WIDTH(4), .DEPTH(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_diff(out_diff), .out_borrow(out_borrow),
        .count(count), .full(full), .empty(empty), .borrow_cnt(borrow_cnt)
    );

    sub_result_fifo #(.DATA_WIDTH(4), .DEPTH(4), .CNT_WIDTH(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_x(in_x),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_diff(out_diff_s), .out_borrow(out_borrow_s),
        .count(count_s), .full(full_s), .empty(empty_s), .borrow_cnt(borrow_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_model();
        logic [4:0] h;
        int n;
        n = sb.size();
        chk("count", int'(count), n);
        chk("out_valid", int'(out_valid), int'(n != 0));
        chk("empty", int'(empty), int'(n == 0));
        chk("full", int'(full), int'(n == 4));
        chk("in_ready", int'(in_ready), int'(n < 4));
        if (n != 0) h = sb[0];
        else h = '0;
        chk("out_diff", int'(out_diff), int'(h[3:0]));
        chk("out_borrow", int'(out_borrow), int'(h[4]));
        chk("borrow_cnt", int'(borrow_cnt), m_bc);
        chk("borrow_cnt_sat", int'(borrow_cnt_s), m_bc2);
    endtask

    task automatic clear_model();
        sb.delete();
        m_bc = 0;
        m_bc2 = 0;
    endtask

    // Drive one cycle of inputs at the falling edge, update the scoreboard
    // for the coming rising edge, then compare at the next falling edge.
    task automatic step(input bit iv, input bit ordy, input bit c, input logic [4:0] x);
        bit         do_push;
        bit         do_pop;
        logic [4:0] exp_head;
        in_valid  = iv;
        out_ready = ordy;
        clr       = c;
        in_x      = x;
        if (c) begin
            clear_model();
        end else begin
            do_push = iv && (sb.size() < 4);
            do_pop  = ordy && (sb.size() > 0);
            if (do_pop) begin
                exp_head = sb.pop_front();
                got.push_back({out_borrow, out_diff});
                chk("pop_data", int'({out_borrow, out_diff}), int'(exp_head));
            end
            if (do_push) begin
                sb.push_back(x);
                if (x[4]) begin
                    if (m_bc < 255) m_bc++;
                    if (m_bc2 < 3) m_bc2++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // single transfer, borrow case, fill / backpressure / drain
        vecs[0]  = '{1, 0, 5'b00101, 1, 1, 5,  0, 0, 0};
        vecs[1]  = '{0, 1, 5'b00000, 0, 0, 0,  0, 0, 0};
        vecs[2]  = '{1, 0, 5'b11110, 1, 1, 14, 1, 0, 1};
        vecs[3]  = '{0, 1, 5'b00000, 0, 0, 0,  0, 0, 1};
        vecs[4]  = '{1, 0, 5'd1,     1, 1, 1,  0, 0, 1};
        vecs[5]  = '{1, 0, 5'd2,     2, 1, 1,  0, 0, 1};
        vecs[6]  = '{1, 0, 5'd3,     3, 1, 1,  0, 0, 1};
        vecs[7]  = '{1, 0, 5'd4,     4, 1, 1,  0, 1, 1};
        vecs[8]  = '{1, 0, 5'd7,     4, 1, 1,  0, 1, 1};
        vecs[9]  = '{1, 1, 5'd7,     3, 1, 2,  0, 0, 1};
        vecs[10] = '{0, 1, 5'd0,     2, 1, 3,  0, 0, 1};
        vecs[11] = '{0, 1, 5'd0,     1, 1, 4,  0, 0, 1};
        vecs[12] = '{0, 1, 5'd0,     0, 0, 0,  0, 0, 1};

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_borrow_cnt", int'(borrow_cnt), 0);
        chk("rst_out_diff", int'(out_diff), 0);
        chk("rst_out_borrow", int'(out_borrow), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].iv, vecs[i].ordy, 1'b0, vecs[i].x);
            chk($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vecs[i].ov));
            chk($sformatf("vec%0d_out_diff", i), int'(out_diff), vecs[i].diff);
            chk($sformatf("vec%0d_out_borrow", i), int'(out_borrow), int'(vecs[i].brw));
            chk($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].fl));
            chk($sformatf("vec%0d_borrow_cnt", i), int'(borrow_cnt), vecs[i].bc);
        end

        // pop request on an empty FIFO is ignored
        step(1'b0, 1'b1, 1'b0, 5'd0);
        chk("empty_pop_count", int'(count), 0);

        // wrap and concurrency: 10 cycles of push+pop
        got.delete();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 5'(i));
            chk($sformatf("wrap%0d_count", i), int'(count), 1);
        end
        step(1'b0, 1'b1, 1'b0, 5'd0);
        chk("wrap_pops", got.size(), 10);
        for (int i = 0; i < 10 && i < got.size(); i++) begin
            chk($sformatf("wrap_order%0d", i), int'(got[i]), i);
        end

        // borrow counter saturation on the CNT_WIDTH=2 instance
        do_reset();
        begin
            int exp_sat[5];
            exp_sat = '{1, 2, 3, 3, 3};
            for (int k = 0; k < 5; k++) begin
                step(1'b1, 1'b1, 1'b0, 5'b10000 + 5'(k));
                chk($sformatf("sat_seq%0d", k), int'(borrow_cnt_s), exp_sat[k]);
            end
        end
        chk("sat_wide_cnt", int'(borrow_cnt), 5);
        step(1'b0, 1'b1, 1'b0, 5'd0);

        // asynchronous reset mid-operation
        do_reset();
        step(1'b1, 1'b0, 1'b0, 5'b10001);
        step(1'b1, 1'b0, 1'b0, 5'b00010);
        step(1'b1, 1'b0, 1'b0, 5'b10011);
        chk("pre_rst_count", int'(count), 3);
        chk("pre_rst_borrow_cnt", int'(borrow_cnt), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_full", int'(full), 0);
        chk("arst_borrow_cnt", int'(borrow_cnt), 0);
        chk("arst_out_diff", int'(out_diff), 0);
        chk("arst_out_borrow", int'(out_borrow), 0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // synchronous clear beats a simultaneous push and pop
        step(1'b1, 1'b0, 1'b0, 5'b10101);
        step(1'b1, 1'b0, 1'b0, 5'b00110);
        chk("pre_clr_count", int'(count), 2);
        step(1'b1, 1'b1, 1'b1, 5'b11000);
        chk("clr_count", int'(count), 0);
        chk("clr_borrow_cnt", int'(borrow_cnt), 0);
        chk("clr_empty", int'(empty), 1);
        step(1'b1, 1'b0, 1'b0, 5'b01001);
        chk("post_clr_diff", int'(out_diff), 9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sub_result_fifo.md
Name: sub_result_fifo

Overview:
- Downstream stage of the combinational subtractor: captures its (DATA_WIDTH+1)-bit result X = A - B into a small FIFO behind a valid/ready handshake.
- Splits each result into a DATA_WIDTH-bit wrapped difference and a borrow flag (X MSB, set when A < B).
- Keeps a saturating count of borrow events for the cocotb bench and for downstream consumers.

Parameters:
- DATA_WIDTH, 4, operand width of the subtractor; the input result is DATA_WIDTH+1 bits.
- DEPTH, 4, FIFO entries; must be a power of 2 and >= 2.
- CNT_WIDTH, 8, width of the saturating borrow counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush of FIFO and counter.
- in_valid  input  1  subtractor result valid.
- in_ready  output  1  FIFO can accept a result.
- in_x  input  DATA_WIDTH+1  subtractor result X.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer takes head entry.
- out_diff  output  DATA_WIDTH  head entry bits [DATA_WIDTH-1:0].
- out_borrow  output  1  head entry bit [DATA_WIDTH].
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- borrow_cnt  output  CNT_WIDTH  number of accepted entries with borrow = 1, saturating.

Behaviour:
- Clock, reset and output values:
  - Single clock domain.
  - The clock is clk; the reset is rst_n, asynchronous and active-low.
  - rst_n low, any time including mid-transfer: read/write pointers, count and borrow_cnt go to 0 immediately. All stored data is discarded.
  - Outputs while in reset: in_ready=1, out_valid=0, empty=1, full=0, count=0, borrow_cnt=0, out_diff=0, out_borrow=0.
- Push: in_valid && in_ready at a rising edge.
  - Writes in_x to the write pointer location, then increments the write pointer modulo DEPTH.
- Pop: out_valid && out_ready at a rising edge.
  - Increments the read pointer modulo DEPTH.
- Derived flags:
  - in_ready = !full. Registered-state only; no combinational dependence on out_ready.
  - out_valid = !empty.
  - out_diff and out_borrow are driven combinationally from the head entry. When empty they read 0 (masked).
- Latency:
  - A push into an empty FIFO raises out_valid the next cycle, carrying that entry.
  - There is no same-cycle bypass.
- Simultaneous push and pop, count neither empty nor full: both occur; count is unchanged.
- Full FIFO:
  - in_ready=0, so no push occurs, even if a pop happens in the same cycle.
  - in_ready rises the cycle after the pop.
- Empty FIFO: a pop request (out_ready=1) is ignored; count stays 0.
- Pointers:
  - Pointers wrap modulo DEPTH.
  - count tracks occupancy exactly across wrap-around, with no ambiguity between full and empty.
- Ordering: strict FIFO order is preserved.
- Borrow counter:
  - On each accepted push with in_x[DATA_WIDTH]=1, borrow_cnt increments by 1.
  - Saturates at 2^CNT_WIDTH-1; no wrap.
  - Pops do not affect it.
- Synchronous clear (clr=1):
  - At the edge, pointers, count and borrow_cnt go to 0.
  - Any push or pop in the same cycle is discarded; clr has priority.
- Arithmetic: no arithmetic on the data path. in_x is stored verbatim; the difference is split as out_diff = X mod 2^DATA_WIDTH, out_borrow = X[DATA_WIDTH].
- X or Z on in_x is stored as-is. in_valid must not be X after reset.

Test Plan:
- Single transfer: push A=9,B=4 (in_x=5'b00101) into an empty FIFO.
  - Next cycle: out_valid=1, out_diff=5, out_borrow=0, count=1.
  - Pop: empty=1, borrow_cnt=0.
- Borrow case: push A=3,B=5 (in_x=5'b11110).
  - Head shows out_diff=14, out_borrow=1; borrow_cnt=1.
- Fill and backpressure, out_ready=0:
  - Push X=1,2,3,4; full=1, in_ready=0, count=4.
  - A 5th in_valid with X=7 is not accepted.
  - Then out_ready=1: pops yield 1,2,3,4 in order; in_ready rises one cycle after the first pop.
- Wrap and concurrency: continuous in_valid=1 and out_ready=1 for 10 cycles with X=0..9.
  - Outputs are 0..9 in order; count holds 1 after the first cycle.
  - Pointers wrap twice.
- Counter saturation: CNT_WIDTH=2, push 5 borrow results (in_x MSB=1).
  - borrow_cnt sequence 1,2,3,3,3.
- Reset and clear mid-operation:
  - With count=3 and borrow_cnt=2, assert rst_n=0 between clock edges: outputs immediately go to reset values.
  - Separately, with count=2, clr=1 together with in_valid=1 and out_ready=1: next cycle count=0, borrow_cnt=0, empty=1.
